sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter and sequencer for the single-port simulation RAM (`spram`). It shares the one RAM port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request at a time through valid/ready handshakes and drives the RAM's enable, write-enable, address, data and mask for exactly one cycle. It captures the one-cycle-latency read data and returns it on a per-requester response handshake. The block sits between the core's fetch/LSU stages and `spram` in non-SoC builds.

## Interface
- `WIDTH`, 32: address and data width; mask width is `WIDTH/8`.

- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `ifu_req_valid_i`  in  1  IFU read request valid
- `ifu_req_ready_o`  out  1  IFU request accepted this cycle
- `ifu_addr_i`  in  WIDTH  IFU read address
- `ifu_resp_valid_o`  out  1  IFU read data valid
- `ifu_resp_ready_i`  in  1  IFU consumes response
- `ifu_rdata_o`  out  WIDTH  IFU read data
- `lsu_req_valid_i`  in  1  LSU request valid
- `lsu_req_ready_o`  out  1  LSU request accepted this cycle
- `lsu_wen_i`  in  1  1 = write, 0 = read
- `lsu_addr_i`  in  WIDTH  LSU address
- `lsu_wdata_i`  in  WIDTH  LSU write data
- `lsu_wmask_i`  in  WIDTH/8  LSU byte write mask
- `lsu_resp_valid_o`  out  1  LSU response valid (read data or write ack)
- `lsu_resp_ready_i`  in  1  LSU consumes response
- `lsu_rdata_o`  out  WIDTH  LSU read data; 0 for write acks
- `ram_addr_o`  out  WIDTH  to spram `addr_i`
- `ram_data_o`  out  WIDTH  to spram `data_i`
- `ram_wmask_o`  out  WIDTH/8  to spram `wmask_i`
- `ram_ena_o`  out  1  to spram `ena_i`
- `ram_wen_o`  out  1  to spram `wen_i`
- `ram_rdata_i`  in  WIDTH  from spram `data_o`; valid in the cycle after the enable edge

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Reset state is IDLE.
- **IDLE**
  - If either valid is high, choose a winner by round-robin.
  - Assert only the winner's `*_req_ready_o`, combinationally, in the same cycle.
  - Latch address, wdata, wmask, wen and grant id, then go to ISSUE.
  - IFU requests always latch wen=0, wmask=0, wdata=0.
  - Both `*_req_ready_o` are 0 in every other state.
- **ISSUE**
  - `ram_ena_o`=1; `ram_wen_o`, `ram_addr_o`, `ram_data_o` and `ram_wmask_o` come from the latched values.
  - Next state is WAIT.
  - In all other states `ram_ena_o`=0, `ram_wen_o`=0 and the other RAM outputs are 0.
- **WAIT**
  - For a read, register `ram_rdata_i` into the response register.
  - For a write, load 0 into the response register.
  - Next state is RESP.
- **RESP**
  - Assert the granted port's `*_resp_valid_o`; its `*_rdata_o` shows the response register.
  - Hold both until the matching `*_resp_ready_i` is 1, then go to IDLE.
  - The non-granted port's resp_valid stays 0.
  - Both `*_rdata_o` are 0 whenever their resp_valid is 0.
- **Round-robin**
  - A 1-bit `last_grant` register updates on each acceptance.
  - When both ports request in IDLE, the port not granted last wins.
  - `last_grant` resets to LSU, so IFU wins the first contention.
  - A single requester is always granted, regardless of `last_grant`.
- **Request stability**
  - Requester inputs are sampled only in the accept cycle.
  - Changes after acceptance have no effect.
  - Dropping valid while in a non-IDLE state is legal.

## Timing
- Accept in cycle 0, RAM enable in cycle 1, capture in cycle 2, resp_valid from cycle 3 at the earliest.
- With resp_ready held high, a new request is accepted in cycle 4, so throughput is one access per 4 cycles.
- Reset values: every output is 0; FSM is IDLE; `last_grant`=LSU; response register is 0.
- Asserting `rst_i` mid-transaction aborts immediately and asynchronously.
  - All outputs go to 0, including ram_ena and resp_valid.
  - The pending response is discarded and never reissued after reset.
- A request arriving while the FSM is busy waits, with ready=0, and is accepted on the first IDLE cycle.
- Response backpressure of any length stalls the FSM in RESP; no RAM access occurs during the stall.

## Test plan
- **Single IFU read**: preload RAM[0x80000000]=0xDEADBEEF; IFU request at cycle 0 -> ifu_req_ready=1 in cycle 0, ram_ena=1 and wen=0 in cycle 1, ifu_resp_valid=1 with rdata=0xDEADBEEF in cycle 3.
- **LSU write then read**: write addr 0x80000010, data 0x12345678, mask 0xF -> ram_ena=wen=1 and wmask=0xF in cycle 1, lsu_resp_valid with rdata=0 in cycle 3; the following read returns 0x12345678.
- **Contention after reset**: both valid at cycle 0 -> IFU granted first, LSU accepted at cycle 4; with both held valid, grants alternate IFU, LSU, IFU, LSU.
- **Backpressure**: hold lsu_resp_ready=0 for 5 cycles -> resp_valid and rdata are stable throughout, ram_ena stays 0, no request is accepted, and IDLE is entered the cycle after ready rises.
- **Reset mid-operation**: assert rst_i during ISSUE -> all outputs are 0 in the same cycle; after release, a fresh IFU request completes normally with IFU priority.
- **Partial-mask write**: write mask 0x3 with data 0xAABBCCDD over 0x11223344 -> a subsequent read returns 0x1122CCDD.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single port of the simulation RAM (spram) between the
// instruction-fetch unit (read-only) and the load/store unit (read/write).
// It accepts one request at a time and drives one RAM cycle for it. It captures
// the one-cycle-latency read data and returns it on the requester's response
// handshake.
//
// Sequence per access: IDLE (accept) -> ISSUE (RAM enable) -> WAIT (capture)
// -> RESP (hold response until consumed) -> IDLE.
//
// Ports
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   ifu_req_valid_i / ifu_req_ready_o  IFU request handshake, ifu_addr_i
//   ifu_resp_valid_o / ifu_resp_ready_i IFU response handshake, ifu_rdata_o
//   lsu_req_valid_i / lsu_req_ready_o  LSU request handshake with lsu_wen_i,
//                                      lsu_addr_i, lsu_wdata_i, lsu_wmask_i
//   lsu_resp_valid_o / lsu_resp_ready_i LSU response handshake, lsu_rdata_o
//                                      (0 for write acknowledgements)
//   ram_*_o                            to spram addr/data/wmask/ena/wen
//   ram_rdata_i                        spram data_o, valid the cycle after
//                                      the enable edge
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               ifu_req_valid_i,
    output logic               ifu_req_ready_o,
    input  logic [WIDTH-1:0]   ifu_addr_i,
    output logic               ifu_resp_valid_o,
    input  logic               ifu_resp_ready_i,
    output logic [WIDTH-1:0]   ifu_rdata_o,

    input  logic               lsu_req_valid_i,
    output logic               lsu_req_ready_o,
    input  logic               lsu_wen_i,
    input  logic [WIDTH-1:0]   lsu_addr_i,
    input  logic [WIDTH-1:0]   lsu_wdata_i,
    input  logic [WIDTH/8-1:0] lsu_wmask_i,
    output logic               lsu_resp_valid_o,
    input  logic               lsu_resp_ready_i,
    output logic [WIDTH-1:0]   lsu_rdata_o,

    output logic [WIDTH-1:0]   ram_addr_o,
    output logic [WIDTH-1:0]   ram_data_o,
    output logic [WIDTH/8-1:0] ram_wmask_o,
    output logic               ram_ena_o,
    output logic               ram_wen_o,
    input  logic [WIDTH-1:0]   ram_rdata_i
);

    localparam int MASK_W = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Grant identifiers, used both for the current grant and for last_grant.
    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              wen_q, wen_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [WIDTH-1:0]  resp_q, resp_d;

    logic              ifu_win;
    logic              lsu_win;
    logic              resp_taken;

    // Round-robin: IFU wins when it is the only requester or when LSU had the
    // previous grant; otherwise any LSU request wins.
    always_comb begin
        ifu_win = ifu_req_valid_i && (!lsu_req_valid_i || (last_grant_q == GNT_LSU));
        lsu_win = lsu_req_valid_i && !ifu_win;
    end

    assign resp_taken = (gnt_q == GNT_IFU) ? ifu_resp_ready_i : lsu_resp_ready_i;

    // Next-state and capture logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_d       = resp_q;

        unique case (state_q)
            IDLE: begin
                if (ifu_win) begin
                    // Fetches are always plain reads.
                    gnt_d        = GNT_IFU;
                    last_grant_d = GNT_IFU;
                    wen_d        = 1'b0;
                    addr_d       = ifu_addr_i;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    state_d      = ISSUE;
                end else if (lsu_win) begin
                    gnt_d        = GNT_LSU;
                    last_grant_d = GNT_LSU;
                    wen_d        = lsu_wen_i;
                    addr_d       = lsu_addr_i;
                    wdata_d      = lsu_wdata_i;
                    wmask_d      = lsu_wmask_i;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Writes are acknowledged with zero data.
                resp_d  = wen_q ? '0 : ram_rdata_i;
                state_d = RESP;
            end
            RESP: begin
                if (resp_taken) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LSU;
            gnt_q        <= GNT_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_q       <= resp_d;
        end
    end

    // Output decode. Everything except the request readies depends only on
    // registered state; the readies must answer in the accept cycle. They are
    // also gated by rst_i so that every output reads 0 while reset is held.
    always_comb begin
        ifu_req_ready_o  = 1'b0;
        lsu_req_ready_o  = 1'b0;
        ram_ena_o        = 1'b0;
        ram_wen_o        = 1'b0;
        ram_addr_o       = '0;
        ram_data_o       = '0;
        ram_wmask_o      = '0;
        ifu_resp_valid_o = 1'b0;
        ifu_rdata_o      = '0;
        lsu_resp_valid_o = 1'b0;
        lsu_rdata_o      = '0;

        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    ifu_req_ready_o = ifu_win;
                    lsu_req_ready_o = lsu_win;
                end
                ISSUE: begin
                    ram_ena_o   = 1'b1;
                    ram_wen_o   = wen_q;
                    ram_addr_o  = addr_q;
                    ram_data_o  = wdata_q;
                    ram_wmask_o = wmask_q;
                end
                RESP: begin
                    if (gnt_q == GNT_IFU) begin
                        ifu_resp_valid_o = 1'b1;
                        ifu_rdata_o      = resp_q;
                    end else begin
                        lsu_resp_valid_o = 1'b1;
                        lsu_rdata_o      = resp_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. It has a small behavioural spram (16 words,
// indexed by addr[5:2]) attached to the RAM port. A transaction-level
// reference model is kept beside it: one outstanding access, a round-robin
// owner bit, a cycle count since acceptance, and a reference copy of memory.
// Every cycle the model predicts all DUT outputs. Directed scenarios come
// first, then random traffic.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready = 1'b1;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready = 1'b1;
    logic [31:0] lsu_rdata;

    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_wmask;
    logic        ram_ena;
    logic        ram_wen;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.WIDTH(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ifu_req_valid_i  (ifu_req_valid),
        .ifu_req_ready_o  (ifu_req_ready),
        .ifu_addr_i       (ifu_addr),
        .ifu_resp_valid_o (ifu_resp_valid),
        .ifu_resp_ready_i (ifu_resp_ready),
        .ifu_rdata_o      (ifu_rdata),
        .lsu_req_valid_i  (lsu_req_valid),
        .lsu_req_ready_o  (lsu_req_ready),
        .lsu_wen_i        (lsu_wen),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .lsu_wmask_i      (lsu_wmask),
        .lsu_resp_valid_o (lsu_resp_valid),
        .lsu_resp_ready_i (lsu_resp_ready),
        .lsu_rdata_o      (lsu_rdata),
        .ram_addr_o       (ram_addr),
        .ram_data_o       (ram_data),
        .ram_wmask_o      (ram_wmask),
        .ram_ena_o        (ram_ena),
        .ram_wen_o        (ram_wen),
        .ram_rdata_i      (ram_rdata)
    );

    // Behavioural spram with a preload port used while the DUT is in reset.
    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (ram_ena) begin
            if (ram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wmask[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_data[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[5:2]];
            end
        end
    end

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    logic [31:0] ref_mem [16];
    bit          m_busy  = 1'b0;
    int          m_age   = 0;      // cycles since acceptance
    bit          m_owner = 1'b0;   // 0 = IFU, 1 = LSU
    bit          m_last  = 1'b1;   // previous grant, LSU after reset
    bit          m_wen   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_mask  = '0;
    logic [31:0] m_rdata = '0;

    bit          acc_ifu, acc_lsu;          // model acceptance this cycle
    bit          obs_acc_ifu, obs_acc_lsu;  // DUT readies this cycle
    logic [31:0] seen_ifu, seen_lsu;        // last consumed response data

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // One clock: compare at the falling edge, advance the model, return 1ns
    // after the next rising edge so the caller can set up new inputs.
    task automatic cycle();
        bit e_ir, e_lr, issue, rv;
        @(negedge clk);
        e_ir  = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
        e_lr  = !m_busy && lsu_req_valid && !e_ir;
        issue = m_busy && (m_age == 1);
        rv    = m_busy && (m_age >= 3);

        check("ifu_req_ready", 32'(ifu_req_ready), 32'(e_ir));
        check("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lr));
        check("ram_ena",   32'(ram_ena), 32'(issue));
        check("ram_wen",   32'(ram_wen), 32'(issue && m_wen));
        check("ram_addr",  ram_addr,  issue ? m_addr  : 32'h0);
        check("ram_data",  ram_data,  issue ? m_wdata : 32'h0);
        check("ram_wmask", 32'(ram_wmask), issue ? 32'(m_mask) : 32'h0);
        check("ifu_resp_valid", 32'(ifu_resp_valid), 32'(rv && !m_owner));
        check("ifu_rdata", ifu_rdata, (rv && !m_owner) ? m_rdata : 32'h0);
        check("lsu_resp_valid", 32'(lsu_resp_valid), 32'(rv && m_owner));
        check("lsu_rdata", lsu_rdata, (rv && m_owner) ? m_rdata : 32'h0);

        acc_ifu     = e_ir;
        acc_lsu     = e_lr;
        obs_acc_ifu = ifu_req_ready;
        obs_acc_lsu = lsu_req_ready;

        if (m_busy) begin
            if (issue) begin
                if (m_wen) begin
                    ref_mem[m_addr[5:2]] = merge(ref_mem[m_addr[5:2]], m_wdata, m_mask);
                    m_rdata = '0;
                end else begin
                    m_rdata = ref_mem[m_addr[5:2]];
                end
            end
            if (rv && (m_owner ? lsu_resp_ready : ifu_resp_ready)) begin
                if (m_owner) seen_lsu = lsu_rdata; else seen_ifu = ifu_rdata;
                m_busy = 1'b0;
            end else if (m_age < 3) begin
                m_age++;
            end
        end else if (e_ir || e_lr) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_owner = e_lr;
            m_last  = e_lr;
            m_wen   = e_lr ? lsu_wen   : 1'b0;
            m_addr  = e_lr ? lsu_addr  : ifu_addr;
            m_wdata = e_lr ? lsu_wdata : 32'h0;
            m_mask  = e_lr ? lsu_wmask : 4'h0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_rdy"},  32'(ifu_req_ready), 32'h0);
        check({tag, "_lsu_rdy"},  32'(lsu_req_ready), 32'h0);
        check({tag, "_ena"},      32'(ram_ena), 32'h0);
        check({tag, "_wen"},      32'(ram_wen), 32'h0);
        check({tag, "_addr"},     ram_addr, 32'h0);
        check({tag, "_data"},     ram_data, 32'h0);
        check({tag, "_wmask"},    32'(ram_wmask), 32'h0);
        check({tag, "_ifu_rv"},   32'(ifu_resp_valid), 32'h0);
        check({tag, "_ifu_rd"},   ifu_rdata, 32'h0);
        check({tag, "_lsu_rv"},   32'(lsu_resp_valid), 32'h0);
        check({tag, "_lsu_rd"},   lsu_rdata, 32'h0);
    endtask

    // Present one request, wait for acceptance, scramble the inputs, then wait
    // for the response to be consumed (resp_ready held high).
    task automatic txn(input bit is_lsu, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
        bit done;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = addr;
            lsu_wdata = wdata; lsu_wmask = mask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            if (is_lsu ? acc_lsu : acc_ifu) done = 1'b1;
        end
        if (!done) check("txn_accept_timeout", 32'h0, 32'h1);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
        for (int i = 0; i < 20 && m_busy; i++) cycle();
        if (m_busy) check("txn_resp_timeout", 32'h0, 32'h1);
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h8000_0000 | {26'h0, 4'($urandom), 2'b00};
    endfunction

    int          grant_owner [$];
    int          grant_cycle [$];
    bit          bp_done;

    initial begin
        seen_ifu = '0;
        seen_lsu = '0;

        // Reset with memory preload; outputs must all read 0 meanwhile.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            pl_en  = 1'b1;
            pl_idx = 4'(i);
            pl_val = (i == 0) ? 32'hDEAD_BEEF : (i == 5) ? 32'h1122_3344 : $urandom;
            ref_mem[i] = pl_val;
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single IFU read.
        txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        check("ifu_read_deadbeef", seen_ifu, 32'hDEAD_BEEF);

        // LSU write then read back.
        txn(1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
        check("lsu_write_ack", seen_lsu, 32'h0);
        txn(1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
        check("lsu_read_back", seen_lsu, 32'h1234_5678);

        // Partial-mask write.
        txn(1'b1, 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'h3);
        txn(1'b1, 1'b0, 32'h8000_0014, 32'h0, 4'h0);
        check("partial_mask_read", seen_lsu, 32'h1122_CCDD);

        // Backpressure: LSU read held in RESP for 5 cycles while IFU waits.
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0000;
        lsu_resp_ready = 1'b0;
        cycle();
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        for (int i = 0; i < 7; i++) cycle();   // 2 cycles to RESP + 5 stalled
        lsu_resp_ready = 1'b1;
        cycle();                               // response consumed
        bp_done = 1'b0;
        for (int i = 0; i < 4 && !bp_done; i++) begin
            cycle();
            if (acc_ifu) bp_done = 1'b1;
        end
        check("bp_ifu_accept_after_release", 32'(obs_acc_ifu), 32'h1);
        ifu_req_valid = 1'b0;
        for (int i = 0; i < 20 && m_busy; i++) cycle();

        // Reset during ISSUE.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        cycle();
        ifu_req_valid = 1'b0;
        check("pre_reset_ena", 32'(ram_ena), 32'h1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst    = 1'b0;
        m_busy = 1'b0;
        m_last = 1'b1;

        // Contention right after reset: both held valid, grants alternate.
        ifu_req_valid = 1'b1; ifu_addr = rnd_addr();
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = rnd_addr();
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (obs_acc_ifu) begin grant_owner.push_back(0); grant_cycle.push_back(c); end
            if (obs_acc_lsu) begin grant_owner.push_back(1); grant_cycle.push_back(c); end
            ifu_addr = rnd_addr();
            lsu_addr = rnd_addr();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        check("cont_grant_count", 32'(grant_owner.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_owner.size(); k++) begin
            check($sformatf("cont_owner_%0d", k), 32'(grant_owner[k]), 32'(k % 2));
            check($sformatf("cont_cycle_%0d", k), 32'(grant_cycle[k]), 32'(4 * k));
        end
        for (int i = 0; i < 20 && m_busy; i++) cycle();

        // Random traffic with random response backpressure.
        for (int c = 0; c < 800; c++) begin
            if (!ifu_req_valid && ($urandom_range(0, 2) == 0)) begin
                ifu_req_valid = 1'b1; ifu_addr = rnd_addr();
            end
            if (!lsu_req_valid && ($urandom_range(0, 2) == 0)) begin
                lsu_req_valid = 1'b1; lsu_wen = 1'($urandom); lsu_addr = rnd_addr();
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            end
            ifu_resp_ready = ($urandom_range(0, 3) != 0);
            lsu_resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc_ifu) begin ifu_req_valid = 1'b0; ifu_addr = $urandom; end
            if (acc_lsu) begin
                lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
                lsu_wen = 1'($urandom); lsu_wmask = 4'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
